fft_frame_collector: RTL and testbench
======================================

# fft_frame_collector

Serial-to-parallel frame collector for the FFT core input path. It accepts a serial sample stream over a valid/ready handshake and writes each sample into a parallel frame register by a write-index counter, in natural or bit-reversed order. When the frame is complete it presents all POINTS samples in parallel to the FFT datapath with a valid/ready handshake. It is the sequenced writer counterpart to the FFT core's registered mux/demux select paths.

## Interface
- DATA_WIDTH, 8: sample width in bits.
- POINTS, 16: frame length. Power of two, 2..2048.
- BIT_REV, 0: 0 stores sample k at index k. 1 stores sample k at index bitrev(k) over log2(POINTS) bits.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  collector can accept a sample.
- s_data  in  DATA_WIDTH  input sample.
- s_last  in  1  marks the final sample of a frame.
- m_valid  out  1  parallel frame valid.
- m_ready  in  1  consumer accepts the frame.
- m_data  out  DATA_WIDTH x [POINTS]  parallel frame, unpacked array.
- fill_cnt  out  $clog2(POINTS)+1  samples accepted in the current frame.
- frame_err  out  1  one-cycle pulse on a framing error.

## Operation
- Reset (asynchronous, while rst_n=0):
  - state=IDLE, s_ready=0, m_valid=0, frame_err=0, fill_cnt=0.
  - All m_data entries are 0.
  - A partial frame is discarded.
- FSM transitions:
  - IDLE: unconditionally goes to FILL on the first clk edge after rst_n deasserts.
  - FILL: s_ready=1. A beat is accepted on an edge where s_valid && s_ready.
    - On each accepted beat, m_data[addr(fill_cnt)] <= s_data and fill_cnt increments.
    - addr is identity or bit-reverse per BIT_REV.
  - FILL, beat index POINTS-1 accepted: go to HOLD and set fill_cnt=POINTS.
  - HOLD: s_ready=0, m_valid=1, m_data frozen.
    - On an edge with m_ready=1: go to FILL, fill_cnt=0, m_valid=0.
- s_ready and m_valid are decoded directly from registered state. There is no combinational path from m_ready to s_ready.
- Framing errors:
  - s_last on an accepted beat with index < POINTS-1:
    - The sample is written.
    - frame_err pulses.
    - fill_cnt returns to 0 and the state stays FILL. The short frame is discarded and never presented.
    - Stale m_data entries remain until overwritten.
  - s_last=0 on beat POINTS-1: frame_err pulses and the frame is still delivered normally.
- m_data entries not written in the current frame keep their previous value. This only occurs after a discarded short frame.

## Timing
- Last beat accepted at edge N: m_valid=1 and s_ready=0 from edge N onward.
- m_data is complete and valid in the same cycle m_valid rises.
- Frame handshake at edge M (m_valid && m_ready): m_valid=0 and s_ready=1 after edge M. The next beat can be accepted at edge M+1.
- Steady-state throughput: POINTS+1 cycles per frame when m_ready is held high (one bubble per frame).
- frame_err is registered: high for exactly the one cycle following the offending beat's edge.
- fill_cnt updates on the same edge as the accepted beat.
- m_valid, once high, stays high with stable m_data until accepted.
- An async reset at any point (mid-FILL, in HOLD, or coincident with a handshake) forces the reset values immediately; reset wins over everything.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with s_valid=1.
  - During reset: s_ready=0, m_valid=0, m_data all 0.
  - s_ready=1 exactly one edge after release.
- **Natural order:** POINTS=16, 16 back-to-back beats 0x10..0x1F, s_last on beat 15, m_ready=0.
  - m_valid rises after beat 15; m_data[i]=0x10+i; s_ready=0; fill_cnt=16.
  - Outputs stay stable for 5 cycles.
  - m_ready pulse: m_valid=0 and s_ready=1 next cycle.
- **Bit-reversed order:** BIT_REV=1, POINTS=16, samples 0x00..0x0F.
  - m_data[8]=0x01, m_data[12]=0x03, m_data[15]=0x0F, m_data[0]=0x00.
- **Short frame:** s_last on beat index 5.
  - frame_err high for one cycle, fill_cnt=0, no m_valid.
  - The next 16-beat frame is delivered with all 16 correct values.
- **Missing s_last:** 16 beats with no s_last.
  - frame_err pulses after beat 15 and the frame is still delivered intact.
- **Gapped input and mid-frame reset:** random s_valid (50%) and random m_ready.
  - Assert rst_n=0 after 7 beats: all outputs clear immediately.
  - The following full frame is correct with fill_cnt=16.
  - Each frame takes at least POINTS+1 cycles.

Source files
------------

// File: rtl/fft_frame_collector.sv
// Serial-to-parallel frame collector: writes a serial sample stream into a
// POINTS-entry frame register (natural or bit-reversed order) and presents it in parallel.
module fft_frame_collector #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned POINTS     = 16,
    parameter int unsigned BIT_REV    = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data [POINTS],
    output logic [$clog2(POINTS):0]   fill_cnt,
    output logic                      frame_err
);

    localparam int unsigned AW = $clog2(POINTS);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           fill_q, fill_d;
    logic                    s_ready_q, s_ready_d;
    logic                    m_valid_q, m_valid_d;
    logic                    err_q, err_d;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [DATA_WIDTH-1:0]   mem_q [POINTS];

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < int'(AW); i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // Frame slot addressed by the running beat index
    always_comb begin
        wr_addr = fill_q[AW-1:0];
        if (BIT_REV != 0) begin
            wr_addr = bitrev(fill_q[AW-1:0]);
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: state_d = FILL;
            FILL: begin
                if (s_valid && s_ready_q) begin
                    wr_en = 1'b1;
                    if (fill_q == CW'(POINTS - 1)) begin
                        state_d = HOLD;
                        fill_d  = CW'(POINTS);
                        err_d   = !s_last;
                    end else if (s_last) begin
                        // Short frame: keep the sample, restart the count, never present it
                        fill_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        fill_d = fill_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d == FILL);
        m_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fill_q    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(POINTS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= s_data;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(POINTS); i++) begin
            m_data[i] = mem_q[i];
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign fill_cnt  = fill_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Testbench for fft_frame_collector: natural and bit-reversed instances share one
// stimulus stream; a scoreboard queue holds expected frames popped at each frame handshake.
module tb_fft_frame_collector;

    localparam int unsigned DW = 8;
    localparam int unsigned P  = 16;
    localparam int unsigned AW = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] s_data  = '0;

    logic          n_s_ready, n_m_valid, n_err;
    logic [DW-1:0] n_data [P];
    logic [AW:0]   n_fill;
    logic          r_s_ready, r_m_valid, r_err;
    logic [DW-1:0] r_data [P];
    logic [AW:0]   r_fill;

    fft_frame_collector #(.DATA_WIDTH(DW), .POINTS(P), .BIT_REV(0)) u_nat (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(n_s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(n_m_valid), .m_ready(m_ready),
        .m_data(n_data), .fill_cnt(n_fill), .frame_err(n_err)
    );

    fft_frame_collector #(.DATA_WIDTH(DW), .POINTS(P), .BIT_REV(1)) u_rev (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(r_s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(r_m_valid), .m_ready(m_ready),
        .m_data(r_data), .fill_cnt(r_fill), .frame_err(r_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [P*DW-1:0] nat;
        logic [P*DW-1:0] rev;
    } frame_t;

    frame_t        sb_q [$];
    frame_t        mon_f;
    frame_t        push_f;
    logic [DW-1:0] mn [P];
    logic [DW-1:0] mr [P];
    int            mcnt     = 0;
    int            last_cyc = -1;

    function automatic logic [AW-1:0] brev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < int'(AW); i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(P); i++) begin
            mn[i] = '0;
            mr[i] = '0;
        end
        mcnt = 0;
    endtask

    // Handshake monitor: the frame accepted at the next edge must match the queue head
    always @(negedge clk) begin
        if (rst_n === 1'b1 && n_m_valid === 1'b1 && m_ready === 1'b1) begin
            chk("rev_mvalid_hs", 32'(r_m_valid), 32'd1);
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_frame", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_f = sb_q.pop_front();
                for (int i = 0; i < int'(P); i++) begin
                    chk($sformatf("nat_data[%0d]", i), 32'(n_data[i]), 32'(mon_f.nat[i*DW +: DW]));
                    chk($sformatf("rev_data[%0d]", i), 32'(r_data[i]), 32'(mon_f.rev[i*DW +: DW]));
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic l, input bit gap);
        bit done;
        int idx;
        done = 1'b0;
        if (gap && $urandom_range(1) == 1) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (n_s_ready === 1'b1) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!done) begin
            chk("send_timeout", 32'(done), 32'd1);
            return;
        end
        idx = mcnt;
        mn[idx] = d;
        mr[brev(AW'(idx))] = d;
        if (idx == int'(P) - 1) begin
            for (int i = 0; i < int'(P); i++) begin
                push_f.nat[i*DW +: DW] = mn[i];
                push_f.rev[i*DW +: DW] = mr[i];
            end
            sb_q.push_back(push_f);
            chk("last_fill", 32'(n_fill), 32'(P));
            chk("last_err", 32'(n_err), 32'(!l));
            chk("last_mvalid", 32'(n_m_valid), 32'd1);
            chk("last_sready", 32'(n_s_ready), 32'd0);
            chk("rev_last_mvalid", 32'(r_m_valid), 32'd1);
            if (last_cyc >= 0) chk("frame_period_min", 32'((cyc - last_cyc) >= int'(P) + 1), 32'd1);
            last_cyc = cyc;
            mcnt = 0;
        end else if (l) begin
            chk("short_err", 32'(n_err), 32'd1);
            chk("short_fill", 32'(n_fill), 32'd0);
            chk("short_mvalid", 32'(n_m_valid), 32'd0);
            mcnt = 0;
        end else begin
            mcnt++;
            chk("fill_cnt", 32'(n_fill), 32'(mcnt));
            chk("beat_err", 32'(n_err), 32'd0);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input logic lastflag, input bit gap);
        for (int k = 0; k < int'(P); k++) begin
            send(base + DW'(k), (k == int'(P) - 1) ? lastflag : 1'b0, gap);
        end
    endtask

    task automatic recv(input int hold);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            if (n_m_valid === 1'b1) seen = 1'b1;
        end
        chk("recv_timeout", 32'(seen), 32'd1);
        if (!seen) return;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_mvalid", 32'(n_m_valid), 32'd1);
            chk("hold_sready", 32'(n_s_ready), 32'd0);
            chk("hold_fill", 32'(n_fill), 32'(P));
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("post_mvalid", 32'(n_m_valid), 32'd0);
        chk("post_sready", 32'(n_s_ready), 32'd1);
        chk("post_fill", 32'(n_fill), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_sready"}, 32'(n_s_ready), 32'd0);
        chk({tag, "_mvalid"}, 32'(n_m_valid), 32'd0);
        chk({tag, "_fill"}, 32'(n_fill), 32'd0);
        chk({tag, "_err"}, 32'(n_err), 32'd0);
        chk({tag, "_rev_sready"}, 32'(r_s_ready), 32'd0);
        for (int i = 0; i < int'(P); i++) begin
            chk($sformatf("%s_nat[%0d]", tag, i), 32'(n_data[i]), 32'd0);
            chk($sformatf("%s_rev[%0d]", tag, i), 32'(r_data[i]), 32'd0);
        end
    endtask

    initial begin
        int c0;
        model_clear();
        s_valid = 1'b1;
        s_data  = 8'hAA;
        rst_n   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_sready", 32'(n_s_ready), 32'd0);
            chk("rst_mvalid", 32'(n_m_valid), 32'd0);
        end
        check_cleared("rst");
        rst_n = 1'b1;
        #1;
        chk("idle_sready", 32'(n_s_ready), 32'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("first_sready", 32'(n_s_ready), 32'd1);
        chk("first_fill", 32'(n_fill), 32'd0);

        // natural order, held for 5 cycles
        send_frame(8'h10, 1'b1, 1'b0);
        recv(5);

        // bit-reversed order
        send_frame(8'h00, 1'b1, 1'b0);
        chk("brev_8", 32'(r_data[8]), 32'h01);
        chk("brev_12", 32'(r_data[12]), 32'h03);
        chk("brev_15", 32'(r_data[15]), 32'h0F);
        chk("brev_0", 32'(r_data[0]), 32'h00);
        chk("nat_8", 32'(n_data[8]), 32'h08);
        recv(0);

        // short frame, s_last on index 5
        for (int k = 0; k < 6; k++) send(8'h40 + DW'(k), (k == 5), 1'b0);
        @(posedge clk); #1;
        chk("err_one_cycle", 32'(n_err), 32'd0);
        chk("short_no_mvalid", 32'(n_m_valid), 32'd0);
        send_frame(8'h50, 1'b1, 1'b0);
        recv(1);

        // missing s_last
        send_frame(8'h60, 1'b0, 1'b0);
        recv(0);

        // steady-state throughput with m_ready held high
        m_ready = 1'b1;
        send_frame(8'h70, 1'b1, 1'b0);
        c0 = last_cyc;
        send_frame(8'h80, 1'b1, 1'b0);
        chk("throughput", 32'(last_cyc - c0), 32'(P + 1));
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("tp_post_sready", 32'(n_s_ready), 32'd1);
        chk("tp_post_mvalid", 32'(n_m_valid), 32'd0);

        // gapped input, mid-frame reset after 7 beats
        for (int k = 0; k < 7; k++) send(8'h90 + DW'(k), 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_release_sready", 32'(n_s_ready), 32'd1);
        send_frame(8'hA0, 1'b1, 1'b1);
        recv(int'($urandom_range(3)));
        send_frame(8'hB0, 1'b1, 1'b1);
        recv(int'($urandom_range(3)));

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
